display_scan_arbiter: RTL and testbench
=======================================

DISPLAY_SCAN_ARBITER -- requirements
Module: display_scan_arbiter

Interface
REQ-001 The block SHALL have parameter DIGIT_W, default 4, meaning width of one digit code sent to the 7-segment decoder.
REQ-002 The block SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per digit slot (minimum 2).
REQ-003 The block SHALL have parameter HOLD_FRAMES, default 8, meaning minimum whole frames an owner keeps the display while the other side requests (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_a, input, 1 bit: requester A wants the display.
REQ-007 The block SHALL have port data_a, input, 4*DIGIT_W bits: A's four digits; bits [DIGIT_W-1:0] are digit0 (rightmost).
REQ-008 The block SHALL have ports req_b and data_b, inputs, same widths and meanings as req_a and data_a, for requester B.
REQ-009 The block SHALL have ports gnt_a and gnt_b, outputs, 1 bit each: the current display owner.
REQ-010 The block SHALL have port decoder_in, output, DIGIT_W bits: the digit code for the external decoder.
REQ-011 The block SHALL have port an, output, 4 bits, active-low anode enables; bit n is digit n.
REQ-012 The block SHALL have port dp, output, 1 bit, active-low decimal point.

Function
REQ-013 Prescaler: counts 0..SCAN_DIV-1, wraps to 0; scan_tick SHALL be asserted in the cycle where count == SCAN_DIV-1.
REQ-014 Digit index idx (2 bits): advances by 1 on each scan_tick, wrapping 3->0; frame_end SHALL be scan_tick AND idx == 3.
REQ-015 Arbiter states SHALL be IDLE, OWN_A, OWN_B, and state transitions SHALL occur only on frame_end.
REQ-016 IDLE at frame_end: if only one side requests, the block SHALL go to that side's OWN state; if both request, it SHALL go to the side not granted last; if none request, it SHALL stay in IDLE.
REQ-017 OWN_x at frame_end: if req_x is low, the block SHALL go to OWN_other when the other side requests, else to IDLE.
REQ-018 OWN_x at frame_end: if req_x is high, the other side requests and held >= HOLD_FRAMES-1, the block SHALL go to OWN_other; otherwise it SHALL stay in OWN_x.
REQ-019 held: SHALL clear on entry to any OWN state, increment on each frame_end spent in the same OWN state, and saturate at HOLD_FRAMES.
REQ-020 last-granted flag: SHALL update on entry to OWN_A or OWN_B.
REQ-021 gnt_a and gnt_b SHALL be registered, one-hot or zero, and equal to (state==OWN_A, state==OWN_B).
REQ-022 an, decoder_in and dp SHALL be registered and update only on scan_tick edges, using the post-transition state and the new idx, so the first slot of a new owner is digit0.
REQ-023 When the post-tick state is OWN_x: an SHALL be ~(1<<idx) and decoder_in SHALL be data_x[idx*DIGIT_W +: DIGIT_W], sampled live at that edge.
REQ-024 When the post-tick state is IDLE: an SHALL be 4'b1111 and decoder_in SHALL be 0.
REQ-025 dp SHALL be 0 only when the owner is B and idx == 0; otherwise dp SHALL be 1.
REQ-026 Request deassertion mid-frame SHALL NOT shorten the frame: the owner's digits are shown until frame_end.
REQ-027 Requests that pulse and drop between frame_ends SHALL be ignored.

Reset
REQ-028 While reset is high at a clk edge, the block SHALL set: count=0, idx=0, state=IDLE, held=0, last=B (so A wins the first tie), gnt_a=gnt_b=0, an=4'b1111, decoder_in=0, dp=1.
REQ-029 Reset SHALL take priority over all other events and SHALL abort any frame in progress.

Verification
Bench parameters: SCAN_DIV=4, HOLD_FRAMES=2, DIGIT_W=4.
REQ-030 Reset, then no requests for 200 cycles -> an=1111, gnt=00, decoder_in=0, dp=1 throughout.
REQ-031 req_a=1, data_a=16'h1234 from reset release -> gnt_a rises at the first frame_end (cycle 16); then an/decoder_in cycle 1110/4, 1101/3, 1011/2, 0111/1, holding each for 4 cycles.
REQ-032 req_a=req_b=1 from reset -> A owns frames 1-2, B owns frames 3-4, then A again; gnt is never 11; dp=0 only during B's digit0 slots.
REQ-033 A owns the display and drops req_a at idx=1 with req_b=0 -> A's digits continue to frame_end, then IDLE with an=1111.
REQ-034 req_a pulses high for 3 cycles between frame_ends -> no grant and no state change.
REQ-035 Reset asserted for 1 cycle mid-frame while B owns -> all reset values on the next edge; scan restarts at count 0, idx 0.

Source files
------------

// File: rtl/display_scan_arbiter.sv
// display_scan_arbiter
//
// Shares one 4-digit multiplexed 7-segment display between two requesters.
// A prescaler produces one scan_tick per digit slot; four slots form a frame.
// Ownership changes only at frame boundaries. An owner that is still
// requesting keeps the display for at least HOLD_FRAMES frames when the other
// side is waiting. When both sides request from IDLE, the side not granted
// last wins.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   req_a, data_a      requester A: request, four packed digits (digit0 in LSBs)
//   req_b, data_b      requester B: same as A
//   gnt_a, gnt_b       registered owner indication, one-hot or zero
//   decoder_in         registered digit code for the external 7-segment decoder
//   an                 registered active-low anode enables, bit n = digit n
//   dp                 registered active-low decimal point (lit on B's digit0)

module display_scan_arbiter #(
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_a,
    input  logic [4*DIGIT_W-1:0] data_a,
    input  logic                 req_b,
    input  logic [4*DIGIT_W-1:0] data_b,
    output logic                 gnt_a,
    output logic                 gnt_b,
    output logic [DIGIT_W-1:0]   decoder_in,
    output logic [3:0]           an,
    output logic                 dp
);

    localparam int unsigned CntW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HeldW = $clog2(HOLD_FRAMES + 1);

    localparam logic [CntW-1:0]  CntMax  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0]  CntOne  = CntW'(1);
    localparam logic [HeldW-1:0] HeldSat = HeldW'(HOLD_FRAMES);
    localparam logic [HeldW-1:0] HeldMin = HeldW'(HOLD_FRAMES - 1);
    localparam logic [HeldW-1:0] HeldOne = HeldW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StOwnA,
        StOwnB
    } state_e;

    logic [CntW-1:0]    count_q, count_d;
    logic [1:0]         idx_q, idx_d;
    state_e             state_q, state_d;
    logic [HeldW-1:0]   held_q, held_d;
    // 1 when B was the most recent side to be granted.
    logic               last_b_q, last_b_d;
    logic               gnt_a_q, gnt_a_d;
    logic               gnt_b_q, gnt_b_d;
    logic [3:0]         an_q, an_d;
    logic [DIGIT_W-1:0] dec_q, dec_d;
    logic               dp_q, dp_d;

    logic scan_tick;
    logic frame_end;

    always_comb begin
        count_d  = count_q;
        idx_d    = idx_q;
        state_d  = state_q;
        held_d   = held_q;
        last_b_d = last_b_q;
        an_d     = an_q;
        dec_d    = dec_q;
        dp_d     = dp_q;

        scan_tick = (count_q == CntMax);
        frame_end = scan_tick && (idx_q == 2'd3);

        count_d = scan_tick ? '0 : count_q + CntOne;
        if (scan_tick) begin
            idx_d = idx_q + 2'd1;
        end

        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    // On a tie, last_b_q set means A has the better claim.
                    if (req_a && (!req_b || last_b_q)) begin
                        state_d = StOwnA;
                    end else if (req_b) begin
                        state_d = StOwnB;
                    end
                end
                StOwnA: begin
                    if (!req_a) begin
                        state_d = req_b ? StOwnB : StIdle;
                    end else if (req_b && (held_q >= HeldMin)) begin
                        state_d = StOwnB;
                    end
                end
                StOwnB: begin
                    if (!req_b) begin
                        state_d = req_a ? StOwnA : StIdle;
                    end else if (req_a && (held_q >= HeldMin)) begin
                        state_d = StOwnA;
                    end
                end
                default: state_d = StIdle;
            endcase

            if ((state_d != state_q) && (state_d != StIdle)) begin
                held_d   = '0;
                last_b_d = (state_d == StOwnB);
            end else if ((state_d == state_q) && (state_q != StIdle) && (held_q != HeldSat)) begin
                held_d = held_q + HeldOne;
            end
        end

        // Grants follow the next state so they line up with state_q.
        gnt_a_d = (state_d == StOwnA);
        gnt_b_d = (state_d == StOwnB);

        // Display outputs use the post-tick owner and index, so a new owner
        // starts on digit0.
        if (scan_tick) begin
            unique case (state_d)
                StOwnA: begin
                    an_d  = ~(4'b0001 << idx_d);
                    dec_d = data_a[32'(idx_d) * DIGIT_W +: DIGIT_W];
                end
                StOwnB: begin
                    an_d  = ~(4'b0001 << idx_d);
                    dec_d = data_b[32'(idx_d) * DIGIT_W +: DIGIT_W];
                end
                default: begin
                    an_d  = 4'b1111;
                    dec_d = '0;
                end
            endcase
            dp_d = !((state_d == StOwnB) && (idx_d == 2'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            idx_q    <= 2'd0;
            state_q  <= StIdle;
            held_q   <= '0;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            an_q     <= 4'b1111;
            dec_q    <= '0;
            dp_q     <= 1'b1;
        end else begin
            count_q  <= count_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            held_q   <= held_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            an_q     <= an_d;
            dec_q    <= dec_d;
            dp_q     <= dp_d;
        end
    end

    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign an         = an_q;
    assign decoder_in = dec_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_display_scan_arbiter.sv
// Bench for display_scan_arbiter with SCAN_DIV=4, HOLD_FRAMES=2, DIGIT_W=4.
// A cycle-count based model predicts the outputs and is compared on every
// falling edge; directed scenarios add literal checks at chosen cycles, where
// cycle 0 is the first cycle after the last reset edge.

module tb_display_scan_arbiter;

    localparam int unsigned DW   = 4;
    localparam int unsigned DIV  = 4;
    localparam int unsigned HOLD = 2;

    logic          clk;
    logic          reset;
    logic          req_a;
    logic          req_b;
    logic [4*DW-1:0] data_a;
    logic [4*DW-1:0] data_b;
    logic          gnt_a;
    logic          gnt_b;
    logic [DW-1:0] decoder_in;
    logic [3:0]    an;
    logic          dp;

    int total = 0;
    int bad   = 0;

    display_scan_arbiter #(
        .DIGIT_W    (DW),
        .SCAN_DIV   (DIV),
        .HOLD_FRAMES(HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .decoder_in(decoder_in),
        .an        (an),
        .dp        (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_time: cycles since reset; slot = m_time / DIV; digit = slot % 4.
    // m_owner: 0 none, 1 A, 2 B. m_frames: frame ends survived by current owner.
    int       m_time;
    int       m_owner;
    int       m_last;
    int       m_frames;
    bit       m_valid = 1'b0;
    logic [3:0]    e_an;
    logic [DW-1:0] e_dec;
    logic          e_dp;

    function automatic logic [3:0] anode_for(input int d);
        case (d)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    always @(posedge clk) begin
        int  slot;
        int  nxt;
        int  digit;
        bit  mine;
        bit  theirs;
        if (reset) begin
            m_time   = 0;
            m_owner  = 0;
            m_last   = 2;
            m_frames = 0;
            e_an     = 4'b1111;
            e_dec    = '0;
            e_dp     = 1'b1;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            slot = m_time / DIV;
            if ((m_time % DIV) == DIV - 1) begin
                if ((slot % 4) == 3) begin
                    if (m_owner == 0) begin
                        if (req_a && req_b) nxt = (m_last == 2) ? 1 : 2;
                        else if (req_a)     nxt = 1;
                        else if (req_b)     nxt = 2;
                        else                nxt = 0;
                    end else begin
                        mine   = (m_owner == 1) ? req_a : req_b;
                        theirs = (m_owner == 1) ? req_b : req_a;
                        if (!mine)                                    nxt = theirs ? 3 - m_owner : 0;
                        else if (theirs && m_frames >= int'(HOLD) - 1) nxt = 3 - m_owner;
                        else                                          nxt = m_owner;
                    end
                    if (nxt != m_owner && nxt != 0) begin
                        m_frames = 0;
                        m_last   = nxt;
                    end else if (nxt == m_owner && nxt != 0) begin
                        m_frames++;
                    end
                    m_owner = nxt;
                end
                digit = (slot + 1) % 4;
                if (m_owner == 0) begin
                    e_an  = 4'b1111;
                    e_dec = '0;
                end else begin
                    e_an  = anode_for(digit);
                    e_dec = DW'(((m_owner == 1 ? data_a : data_b) >> (DW * digit)));
                end
                e_dp = !(m_owner == 2 && digit == 0);
            end
            m_time++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model gnt_a", 32'(gnt_a), 32'(m_owner == 1));
            chk("model gnt_b", 32'(gnt_b), 32'(m_owner == 2));
            chk("model an", 32'(an), 32'(e_an));
            chk("model decoder_in", 32'(decoder_in), 32'(e_dec));
            chk("model dp", 32'(dp), 32'(e_dp));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at cycle 0 with the given inputs applied.
    task automatic do_reset(input logic ra, input logic rb,
                            input logic [4*DW-1:0] da, input logic [4*DW-1:0] db);
        @(negedge clk);
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        step(2);
        reset  = 1'b0;
        req_a  = ra;
        req_b  = rb;
        data_a = da;
        data_b = db;
    endtask

    task automatic lit(input string name, input logic ga, input logic gb,
                       input logic [3:0] ea, input logic [DW-1:0] ed, input logic edp);
        chk({name, " gnt"}, {30'd0, gnt_a, gnt_b}, {30'd0, ga, gb});
        chk({name, " an"}, 32'(an), 32'(ea));
        chk({name, " dec"}, 32'(decoder_in), 32'(ed));
        chk({name, " dp"}, 32'(dp), 32'(edp));
    endtask

    initial begin
        reset  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = '0;
        data_b = '0;

        // Idle for 200 cycles.
        do_reset(1'b0, 1'b0, 16'h0000, 16'h0000);
        lit("idle c0", 1'b0, 1'b0, 4'b1111, 4'h0, 1'b1);
        step(200);
        lit("idle c200", 1'b0, 1'b0, 4'b1111, 4'h0, 1'b1);

        // A alone, digits scanned right to left.
        do_reset(1'b1, 1'b0, 16'h1234, 16'hABCD);
        step(15);
        lit("a c15", 1'b0, 1'b0, 4'b1111, 4'h0, 1'b1);
        step(1);
        lit("a c16", 1'b1, 1'b0, 4'b1110, 4'h4, 1'b1);
        step(4);
        lit("a c20", 1'b1, 1'b0, 4'b1101, 4'h3, 1'b1);
        step(4);
        lit("a c24", 1'b1, 1'b0, 4'b1011, 4'h2, 1'b1);
        step(4);
        lit("a c28", 1'b1, 1'b0, 4'b0111, 4'h1, 1'b1);
        step(4);
        lit("a c32", 1'b1, 1'b0, 4'b1110, 4'h4, 1'b1);

        // Both request: A two frames, B two frames, then A.
        do_reset(1'b1, 1'b1, 16'h1234, 16'h5678);
        step(47);
        lit("ab c47", 1'b1, 1'b0, 4'b0111, 4'h1, 1'b1);
        step(1);
        lit("ab c48", 1'b0, 1'b1, 4'b1110, 4'h8, 1'b0);
        step(4);
        lit("ab c52", 1'b0, 1'b1, 4'b1101, 4'h7, 1'b1);
        step(27);
        lit("ab c79", 1'b0, 1'b1, 4'b0111, 4'h5, 1'b1);
        step(1);
        lit("ab c80", 1'b1, 1'b0, 4'b1110, 4'h4, 1'b1);
        step(100);

        // A drops its request mid-frame; frame still completes.
        do_reset(1'b1, 1'b0, 16'hCAFE, 16'h0000);
        step(21);
        req_a = 1'b0;
        step(3);
        lit("drop c24", 1'b1, 1'b0, 4'b1011, 4'hA, 1'b1);
        step(4);
        lit("drop c28", 1'b1, 1'b0, 4'b0111, 4'hC, 1'b1);
        step(4);
        lit("drop c32", 1'b0, 1'b0, 4'b1111, 4'h0, 1'b1);

        // Short pulse between frame ends is ignored.
        do_reset(1'b0, 1'b0, 16'h9999, 16'h0000);
        step(3);
        req_a = 1'b1;
        step(3);
        req_a = 1'b0;
        step(10);
        lit("pulse c16", 1'b0, 1'b0, 4'b1111, 4'h0, 1'b1);
        step(20);
        lit("pulse c36", 1'b0, 1'b0, 4'b1111, 4'h0, 1'b1);

        // Reset for one cycle while B owns; scan restarts from scratch.
        do_reset(1'b0, 1'b1, 16'h0000, 16'h4321);
        step(16);
        lit("rst c16", 1'b0, 1'b1, 4'b1110, 4'h1, 1'b0);
        step(6);
        reset = 1'b1;
        step(1);
        lit("rst applied", 1'b0, 1'b0, 4'b1111, 4'h0, 1'b1);
        reset = 1'b0;
        step(15);
        lit("rst again c15", 1'b0, 1'b0, 4'b1111, 4'h0, 1'b1);
        step(1);
        lit("rst again c16", 1'b0, 1'b1, 4'b1110, 4'h1, 1'b0);
        step(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
